dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port. It replaces the zero-wait single-cycle data memory model with a valid/ready request/response target that has a parameterised latency.
- The CPU MEM stage acts as the initiator. It drives requests and stalls on the `busy` output until the response arrives.
- The block owns the data storage array. Addresses are byte addresses; storage is 16-bit halfwords.

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: valid/ready request/response target
// with a fixed, parameterised latency in front of a halfword storage array.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_wr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [15:0]           mem_r [DEPTH];
  state_t                state_r;
  logic [3:0]            count_r;
  logic                  lat_wr_r;
  logic [DEPTH_LOG2-1:0] lat_idx_r;
  logic [15:0]           lat_wdata_r;

  logic                  accept_s;
  logic                  commit_s;
  logic                  commit_wr_s;
  logic [DEPTH_LOG2-1:0] commit_idx_s;
  logic [15:0]           commit_wdata_s;
  logic [DEPTH_LOG2-1:0] req_idx_s;
  logic                  unused_addr_bits;

  assign req_idx_s        = req_addr[DEPTH_LOG2:1];
  assign unused_addr_bits = ^req_addr;

  // rst_n gating keeps a request presented during reset from committing a store.
  assign accept_s = req_valid & req_ready & rst_n;

  // Commit source: the live request for single-cycle latency, else the latched one.
  always_comb begin
    commit_s       = 1'b0;
    commit_wr_s    = lat_wr_r;
    commit_idx_s   = lat_idx_r;
    commit_wdata_s = lat_wdata_r;
    if (state_r == IDLE) begin
      commit_s       = accept_s && (LATENCY == 1);
      commit_wr_s    = req_wr;
      commit_idx_s   = req_idx_s;
      commit_wdata_s = req_wdata;
    end else begin
      commit_s = (state_r == WAIT) && (count_r == 4'd0);
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit_s && commit_wr_s) begin
      mem_r[commit_idx_s] <= commit_wdata_s;
    end
  end

  // Request/response state machine with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= 4'd0;
      lat_wr_r    <= 1'b0;
      lat_idx_r   <= '0;
      lat_wdata_r <= 16'h0000;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'h0000;
      rsp_wr      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            lat_wr_r    <= req_wr;
            lat_idx_r   <= req_idx_s;
            lat_wdata_r <= req_wdata;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            if (LATENCY == 1) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state_r <= WAIT;
              count_r <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (count_r == 4'd0) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          count_r   <= 4'd0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase

      // Response payload is captured only on the commit edge, so it holds under backpressure.
      if (commit_s) begin
        rsp_wr    <= commit_wr_s;
        rsp_rdata <= commit_wr_s ? 16'h0000 : mem_r[commit_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build, LATENCY=1 build and DEPTH_LOG2=4 build.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wr    [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_wr    [3];
  logic        busy      [3];

  int errors = 0;
  int checks = 0;

  dmem_responder dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_wr(rsp_wr[0]), .busy(busy[0])
  );

  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_wr(rsp_wr[1]), .busy(busy[1])
  );

  dmem_responder #(.DEPTH_LOG2(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wr(req_wr[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_wr(rsp_wr[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge; the responder must be idle.
  task automatic issue(input int d, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    tick();
    req_valid[d] = 1'b0;
  endtask

  // Called right after the accept edge; n is cycles from acceptance to rsp_valid.
  task automatic wait_rsp(input int d, output int n, output int busy_cnt);
    n        = 1;
    busy_cnt = (busy[d] === 1'b1) ? 1 : 0;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (busy[d] === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    int n;
    int bc;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_wr[i]    = 1'b0;
      req_addr[i]  = 16'h0000;
      req_wdata[i] = 16'h0000;
      rsp_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata[0]), 32'h0000);
    check("rst_rsp_wr",    32'(rsp_wr[0]),    32'd0);
    check("rst_busy",      32'(busy[0]),      32'd0);
    rst_n = 1'b1;
    tick();

    // Store BEEF to 0x0010 with rsp_ready high.
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    check("st_req_ready_fall", 32'(req_ready[0]), 32'd0);
    check("st_busy_rise",      32'(busy[0]),      32'd1);
    wait_rsp(0, n, bc);
    check("st_latency",   32'(n),            32'd4);
    check("st_busy_cnt",  32'(bc),           32'd4);
    check("st_rsp_wr",    32'(rsp_wr[0]),    32'd1);
    check("st_rsp_rdata", 32'(rsp_rdata[0]), 32'h0000);
    tick();
    check("st_consumed_valid", 32'(rsp_valid[0]), 32'd0);
    check("st_consumed_busy",  32'(busy[0]),      32'd0);
    check("st_consumed_ready", 32'(req_ready[0]), 32'd1);

    // Odd-address load returns the same word.
    issue(0, 1'b0, 16'h0011, 16'h0000);
    wait_rsp(0, n, bc);
    check("ld_odd_latency", 32'(n),            32'd4);
    check("ld_odd_rdata",   32'(rsp_rdata[0]), 32'hBEEF);
    check("ld_odd_wr",      32'(rsp_wr[0]),    32'd0);
    tick();
    check("ld_odd_consumed", 32'(rsp_valid[0]), 32'd0);

    // Backpressure for 6 cycles while a (to-be-ignored) store is presented.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 16'h0010, 16'h0000);
    wait_rsp(0, n, bc);
    check("bp_latency", 32'(n), 32'd4);
    req_wr[0]    = 1'b1;
    req_addr[0]  = 16'h0010;
    req_wdata[0] = 16'h0000;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rsp_rdata", 32'(rsp_rdata[0]), 32'hBEEF);
      check("bp_rsp_wr",    32'(rsp_wr[0]),    32'd0);
      check("bp_req_ready", 32'(req_ready[0]), 32'd0);
      tick();
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
    check("bp_release_ready", 32'(req_ready[0]), 32'd1);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    wait_rsp(0, n, bc);
    check("bp_not_clobbered", 32'(rsp_rdata[0]), 32'hBEEF);
    tick();

    // Reset two cycles into a store abandons it.
    issue(0, 1'b1, 16'h0020, 16'h5555);
    wait_rsp(0, n, bc);
    tick();
    issue(0, 1'b1, 16'h0020, 16'hAAAA);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rw_async_req_ready", 32'(req_ready[0]), 32'd1);
    check("rw_async_busy",      32'(busy[0]),      32'd0);
    check("rw_async_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rw_async_rsp_wr",    32'(rsp_wr[0]),    32'd0);
    tick();
    rst_n = 1'b1;
    issue(0, 1'b0, 16'h0020, 16'h0000);
    wait_rsp(0, n, bc);
    check("rw_not_committed", 32'(rsp_rdata[0]), 32'h5555);
    tick();

    // Reset while holding a store response keeps the committed data.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b1, 16'h0040, 16'h1111);
    wait_rsp(0, n, bc);
    check("rr_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_async_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    issue(0, 1'b0, 16'h0040, 16'h0000);
    wait_rsp(0, n, bc);
    check("rr_committed", 32'(rsp_rdata[0]), 32'h1111);
    tick();

    // LATENCY=1 build: store then load two cycles later.
    issue(1, 1'b1, 16'h0002, 16'h1234);
    check("l1_st_valid", 32'(rsp_valid[1]), 32'd1);
    check("l1_st_wr",    32'(rsp_wr[1]),    32'd1);
    check("l1_st_rdata", 32'(rsp_rdata[1]), 32'h0000);
    tick();
    check("l1_ready_back", 32'(req_ready[1]), 32'd1);
    issue(1, 1'b0, 16'h0002, 16'h0000);
    check("l1_ld_valid", 32'(rsp_valid[1]), 32'd1);
    check("l1_ld_rdata", 32'(rsp_rdata[1]), 32'h1234);
    check("l1_ld_wr",    32'(rsp_wr[1]),    32'd0);
    tick();
    check("l1_ld_consumed", 32'(rsp_valid[1]), 32'd0);

    // DEPTH_LOG2=4 build: 0x0024 aliases 0x0004.
    issue(2, 1'b1, 16'h0004, 16'h7777);
    wait_rsp(2, n, bc);
    tick();
    issue(2, 1'b0, 16'h0024, 16'h0000);
    wait_rsp(2, n, bc);
    check("wrap_valid", 32'(rsp_valid[2]), 32'd1);
    check("wrap_rdata", 32'(rsp_rdata[2]), 32'h7777);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
